load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory interface in the MIPS datapath, placed between the execute/memory stage and the 64-word, word-wide data memory.
- Accepts one load/store request at a time from the pipeline. Drives MemoryRead/MemoryWrite/Address/WriteData and consumes the memory's registered ReadData.
- Does byte/halfword extraction with sign or zero extension.
- Implements sub-word stores as read-modify-write, because the memory has no byte enables.

Parameters:
- ADDR_WIDTH, 6: memory word-address width; memory holds 2**ADDR_WIDTH words.
- CHECK_RANGE, 1: when 1, byte addresses at or above 4*2**ADDR_WIDTH fault.

Ports:
- Clock  input  1  system clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- ReqValid  input  1  pipeline presents a request.
- ReqReady  output  1  unit can accept; high only in IDLE.
- ReqOp  input  3  lsu_op_t: LW, LH, LHU, LB, LBU, SW, SH, SB.
- ReqAddr  input  32  byte address from the ALU.
- ReqWriteData  input  32  store data; sub-word stores use its low bits.
- RespValid  output  1  one-cycle completion pulse.
- RespData  output  32  load result; 0 for stores and faults.
- Misaligned  output  1  qualifies RespValid: alignment fault.
- OutOfRange  output  1  qualifies RespValid: range fault.
- MemoryRead  output  1  memory read strobe.
- MemoryWrite  output  1  memory write strobe.
- MemAddress  output  ADDR_WIDTH  word address, equal to captured addr[ADDR_WIDTH+1:2].
- MemWriteData  output  32  memory write data.
- MemReadData  input  32  memory read data; valid the cycle after MemoryRead.

Behaviour:
- Clock and reset:
  - One clock, Clock. Reset is synchronous and active-high.
  - While Reset is high, and in the cycle after, the state is IDLE and the capture registers are 0.
  - During Reset: ReqReady=0, RespValid=0, Misaligned=0, OutOfRange=0, MemoryRead=0, MemoryWrite=0, MemAddress=0, MemWriteData=0, RespData=0.
- Handshake:
  - A request is accepted on a posedge where ReqValid&&ReqReady. Op, addr and data are captured at that edge.
  - ReqReady is low in every non-IDLE state.
  - There is no response back-pressure. The RespValid pulse is exactly one cycle, and the pipeline stalls on ReqReady.
- Fault check at accept:
  - Misaligned when LW/SW have addr[1:0]!=0, or when LH/LHU/SH have addr[0]!=0.
  - OutOfRange when CHECK_RANGE=1 and addr[31:ADDR_WIDTH+2]!=0.
  - Misaligned has priority; only one flag is set.
- States, with cycle 1 = first cycle after accept:
  - IDLE: ReqReady=1. On accept go to FAULT if faulting, else LD_RD for loads, ST_WR for SW, RMW_RD for SB/SH.
  - FAULT: RespValid=1, the fault flag is set, RespData=0, no memory strobes. Next state IDLE. Latency 1.
  - ST_WR: MemoryWrite=1, MemWriteData=data, RespValid=1. Next state IDLE. Latency 1.
  - LD_RD: MemoryRead=1. Next state LD_RET.
  - LD_RET: MemReadData is valid. RespValid=1 and RespData=extract(MemReadData). Next state IDLE. Latency 2.
  - RMW_RD: MemoryRead=1. Next state RMW_WR.
  - RMW_WR: MemoryWrite=1, MemWriteData=merge(MemReadData, data), RespValid=1. Next state IDLE. Latency 2.
- Memory-side rules:
  - MemoryRead and MemoryWrite are never asserted together.
  - MemAddress holds the captured word address in all non-IDLE states and is 0 in IDLE.
- Byte lanes (little-endian):
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Half h = addr[1] occupies bits [16h+15:16h].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - The merge replaces only the addressed lane with data[7:0] or data[15:0]; the other lanes are preserved.
- Reset mid-operation:
  - Reset overrides all state.
  - Reset asserted during RMW_RD means no write ever occurs and memory is unchanged.
  - Reset during LD_RD suppresses RespValid.
- A request presented while busy is ignored until IDLE; it is not lost while ReqValid is held.
- Throughput: one request per 2 cycles (SW/fault) or 3 cycles (loads/RMW), counting the IDLE accept cycle.

Decomposition:
- lsu_pkg:
  - lsu_op_t enum with encodings LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
  - lsu_state_t enum.
  - Helper functions is_load and is_subword.
  - Byte/half lane width constants.
- One combinational sub-module, lsu_lane_align:
  - Input: op, addr[1:0], word, store data.
  - Output: the load extract result and the store merge word.
  - Keeps the FSM file free of lane muxing.

Test Plan:
- Reset, then SW 0x10 with 0xDEADBEEF -> MemoryWrite high for exactly 1 cycle with MemAddress=4, RespValid in cycle 1. Then LW 0x10 -> MemoryRead in cycle 1, RespData=0xDEADBEEF with RespValid in cycle 2.
- Sub-word loads of word 4 -> LB 0x13 returns 0xFFFFFFDE, LBU 0x13 returns 0x000000DE, LH 0x12 returns 0xFFFFDEAD, LHU 0x10 returns 0x0000BEEF.
- SB 0x11 with data 0x12345677 -> MemoryRead then MemoryWrite on consecutive cycles, word 4 becomes 0xDEAD77EF. Then SH 0x12 with 0xAAAA5555 -> word 4 becomes 0x555577EF.
- LW 0x12 -> Misaligned=1, RespValid in cycle 1, RespData=0, no strobes. LW 0x100 -> OutOfRange=1. LH 0x101 -> Misaligned=1 only.
- SB 0x10 with Reset asserted during RMW_RD -> no MemoryWrite, word 4 unchanged, unit back in IDLE with ReqReady=1 one cycle after reset deasserts.
- ReqValid held high across SW, LW, SB back-to-back -> ReqReady low while busy, each request accepted only in IDLE, 3 RespValid pulses in order with spacing 2, 3, 3 cycles.

Source files
------------

// File: rtl/lsu_pkg.sv
// =============================================================================
// lsu_pkg: shared types and helpers for the load/store unit.
// Revision: 1.0
// =============================================================================
`default_nettype none

package lsu_pkg;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4,
    SW  = 3'd5,
    SH  = 3'd6,
    SB  = 3'd7
  } lsu_op_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FAULT  = 3'd1,
    S_ST_WR  = 3'd2,
    S_LD_RD  = 3'd3,
    S_LD_RET = 3'd4,
    S_RMW_RD = 3'd5,
    S_RMW_WR = 3'd6
  } lsu_state_t;

  function automatic logic is_load(lsu_op_t op);
    return (op == LW) || (op == LH) || (op == LHU) || (op == LB) || (op == LBU);
  endfunction

  function automatic logic is_subword(lsu_op_t op);
    return (op != LW) && (op != SW);
  endfunction

  function automatic logic is_misaligned(lsu_op_t op, logic [1:0] off);
    case (op)
      LW, SW:      return off != 2'b00;
      LH, LHU, SH: return off[0];
      default:     return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_if.sv
// =============================================================================
// load_store_unit_if: pipeline request/response and data-memory bus signals.
// Revision: 1.0
// =============================================================================
`default_nettype none

interface load_store_unit_if
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
);

  logic                  ReqValid;
  logic                  ReqReady;
  lsu_op_t               ReqOp;
  logic [31:0]           ReqAddr;
  logic [31:0]           ReqWriteData;
  logic                  RespValid;
  logic [31:0]           RespData;
  logic                  Misaligned;
  logic                  OutOfRange;
  logic                  MemoryRead;
  logic                  MemoryWrite;
  logic [ADDR_WIDTH-1:0] MemAddress;
  logic [31:0]           MemWriteData;
  logic [31:0]           MemReadData;

  // slave is the load/store unit; master is the pipeline plus data memory
  modport slave (
    input  ReqValid, ReqOp, ReqAddr, ReqWriteData, MemReadData,
    output ReqReady, RespValid, RespData, Misaligned, OutOfRange,
           MemoryRead, MemoryWrite, MemAddress, MemWriteData
  );

  modport master (
    output ReqValid, ReqOp, ReqAddr, ReqWriteData, MemReadData,
    input  ReqReady, RespValid, RespData, Misaligned, OutOfRange,
           MemoryRead, MemoryWrite, MemAddress, MemWriteData
  );

endinterface

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// =============================================================================
// lsu_lane_align: little-endian byte/half extraction and sub-word store merge.
// Revision: 1.0
// =============================================================================
`default_nettype none

module lsu_lane_align
  import lsu_pkg::*;
(
  input  lsu_op_t     op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [BYTE_W-1:0] byte_lane;
  logic [HALF_W-1:0] half_lane;

  always_comb begin
    byte_lane = word[{byte_off, 3'b000} +: BYTE_W];
    half_lane = byte_off[1] ? word[31:16] : word[15:0];

    load_data = '0;
    case (op)
      LW:      load_data = word;
      LH:      load_data = {{(WORD_W-HALF_W){half_lane[HALF_W-1]}}, half_lane};
      LHU:     load_data = {{(WORD_W-HALF_W){1'b0}}, half_lane};
      LB:      load_data = {{(WORD_W-BYTE_W){byte_lane[BYTE_W-1]}}, byte_lane};
      LBU:     load_data = {{(WORD_W-BYTE_W){1'b0}}, byte_lane};
      default: load_data = '0;
    endcase

    // Unaddressed lanes come straight from the word just read back
    store_word = word;
    case (op)
      SW: store_word = store_data;
      SH: begin
        if (byte_off[1]) store_word[31:16] = store_data[HALF_W-1:0];
        else             store_word[15:0]  = store_data[HALF_W-1:0];
      end
      SB:      store_word[{byte_off, 3'b000} +: BYTE_W] = store_data[BYTE_W-1:0];
      default: store_word = word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// =============================================================================
// load_store_unit: single-outstanding load/store initiator for word-wide memory.
// Revision: 1.0
// =============================================================================
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 6,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset,
  load_store_unit_if.slave bus
);

  lsu_state_t            state;
  lsu_state_t            next_state;

  lsu_op_t               cap_op;
  logic [ADDR_WIDTH-1:0] cap_word_addr;
  logic [1:0]            cap_byte_off;
  logic [31:0]           cap_data;
  logic                  cap_mis;
  logic                  cap_oor;

  logic                  accept;
  logic                  req_mis;
  logic                  req_range;
  logic                  req_oor;
  logic [31:0]           load_word;
  logic [31:0]           merge_word;

  assign accept  = bus.ReqValid && bus.ReqReady;
  assign req_mis = is_misaligned(bus.ReqOp, bus.ReqAddr[1:0]);
  assign req_oor = req_range && !req_mis;

  generate
    if (CHECK_RANGE) begin : g_range_check
      assign req_range = |bus.ReqAddr[31:ADDR_WIDTH+2];
    end else begin : g_no_range_check
      assign req_range = 1'b0;
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cap_op        <= LW;
      cap_word_addr <= '0;
      cap_byte_off  <= '0;
      cap_data      <= '0;
      cap_mis       <= 1'b0;
      cap_oor       <= 1'b0;
    end else if (accept) begin
      cap_op        <= bus.ReqOp;
      cap_word_addr <= bus.ReqAddr[ADDR_WIDTH+1:2];
      cap_byte_off  <= bus.ReqAddr[1:0];
      cap_data      <= bus.ReqWriteData;
      cap_mis       <= req_mis;
      cap_oor       <= req_oor;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_mis || req_oor)        next_state = S_FAULT;
          else if (is_load(bus.ReqOp))   next_state = S_LD_RD;
          else if (is_subword(bus.ReqOp)) next_state = S_RMW_RD;
          else                           next_state = S_ST_WR;
        end
      end
      S_LD_RD:  next_state = S_LD_RET;
      S_RMW_RD: next_state = S_RMW_WR;
      default:  next_state = S_IDLE;
    endcase
  end

  lsu_lane_align u_lane_align (
    .op         (cap_op),
    .byte_off   (cap_byte_off),
    .word       (bus.MemReadData),
    .store_data (cap_data),
    .load_data  (load_word),
    .store_word (merge_word)
  );

  // Every output is forced low while Reset is high, whatever the state
  always_comb begin
    bus.ReqReady     = 1'b0;
    bus.RespValid    = 1'b0;
    bus.RespData     = '0;
    bus.Misaligned   = 1'b0;
    bus.OutOfRange   = 1'b0;
    bus.MemoryRead   = 1'b0;
    bus.MemoryWrite  = 1'b0;
    bus.MemAddress   = '0;
    bus.MemWriteData = '0;
    if (!Reset) begin
      if (state != S_IDLE) bus.MemAddress = cap_word_addr;
      case (state)
        S_IDLE:  bus.ReqReady = 1'b1;
        S_FAULT: begin
          bus.RespValid  = 1'b1;
          bus.Misaligned = cap_mis;
          bus.OutOfRange = cap_oor;
        end
        S_ST_WR, S_RMW_WR: begin
          bus.MemoryWrite  = 1'b1;
          bus.MemWriteData = merge_word;
          bus.RespValid    = 1'b1;
        end
        S_LD_RD, S_RMW_RD: bus.MemoryRead = 1'b1;
        S_LD_RET: begin
          bus.RespValid = 1'b1;
          bus.RespData  = load_word;
        end
        default: bus.ReqReady = 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// =============================================================================
// tb_load_store_unit: directed and randomized checks against a memory-level model.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_load_store_unit;
  import lsu_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        mis;
    logic        oor;
    logic [3:0]  lat;
    logic [3:0]  nrd;
    logic [3:0]  nwr;
    logic [3:0]  rd_cyc;
    logic [3:0]  wr_cyc;
    logic [5:0]  addr;
    logic        both;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic mem_clear;
  int   tests = 0;
  int   fails = 0;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_WIDTH(6)) bus ();

  load_store_unit #(.ADDR_WIDTH(6), .CHECK_RANGE(1'b1)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // Data memory: synchronous write, registered read data
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      bus.MemReadData <= '0;
    end else begin
      if (bus.MemoryWrite) mem[bus.MemAddress] <= bus.MemWriteData;
      if (bus.MemoryRead)  bus.MemReadData <= mem[bus.MemAddress];
    end
  end

  // Reference: architectural effect of one request on a word array
  task automatic model(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] data,
                       output obs_t e);
    int          size;
    int          off;
    int          idx;
    logic [31:0] w;
    logic [31:0] mask;
    logic [31:0] lane;
    e    = '0;
    size = (op == LW || op == SW) ? 4 : (op == LH || op == LHU || op == SH) ? 2 : 1;
    off  = int'(addr % 4);
    idx  = int'(addr / 4);
    e.mis = (addr % size) != 0;
    e.oor = !e.mis && (addr >= 32'd256);
    e.lat = 4'd1;
    if (!e.mis && !e.oor) begin
      w      = ref_mem[idx];
      mask   = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      e.addr = idx[5:0];
      if (op == LW || op == LH || op == LHU || op == LB || op == LBU) begin
        lane = (w >> (8 * off)) & mask;
        if ((op == LH || op == LB) && lane[8 * size - 1]) lane = lane | ~mask;
        e.data   = lane;
        e.lat    = 4'd2;
        e.nrd    = 4'd1;
        e.rd_cyc = 4'd1;
      end else if (size == 4) begin
        ref_mem[idx] = data;
        e.nwr    = 4'd1;
        e.wr_cyc = 4'd1;
      end else begin
        ref_mem[idx] = (w & ~(mask << (8 * off))) | ((data & mask) << (8 * off));
        e.lat    = 4'd2;
        e.nrd    = 4'd1;
        e.rd_cyc = 4'd1;
        e.nwr    = 4'd1;
        e.wr_cyc = 4'd2;
      end
    end
  endtask

  // Present a request, return at the mid-point of cycle 1 after acceptance
  task automatic start_req(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] data);
    int waits = 0;
    @(negedge clk);
    bus.ReqValid     = 1'b1;
    bus.ReqOp        = op;
    bus.ReqAddr      = addr;
    bus.ReqWriteData = data;
    while (bus.ReqReady !== 1'b1 && waits < 8) begin
      @(negedge clk);
      waits++;
    end
    if (bus.ReqReady !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL req_ready_timeout: ReqReady=%b required 1", bus.ReqReady);
    end
    @(posedge clk);
    #1;
    bus.ReqValid = 1'b0;
    @(negedge clk);
  endtask

  task automatic issue(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] data,
                       output obs_t o);
    bit done = 0;
    o = '0;
    start_req(op, addr, data);
    for (int c = 1; c <= 6 && !done; c++) begin
      if (c > 1) @(negedge clk);
      if (bus.MemoryRead) begin
        o.nrd    = o.nrd + 4'd1;
        o.rd_cyc = c[3:0];
        o.addr   = bus.MemAddress;
      end
      if (bus.MemoryWrite) begin
        o.nwr    = o.nwr + 4'd1;
        o.wr_cyc = c[3:0];
        o.addr   = bus.MemAddress;
      end
      if (bus.MemoryRead && bus.MemoryWrite) o.both = 1'b1;
      if (bus.RespValid) begin
        o.data = bus.RespData;
        o.mis  = bus.Misaligned;
        o.oor  = bus.OutOfRange;
        o.lat  = c[3:0];
        done   = 1;
      end
    end
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    mem_clear        = 1'b1;
    bus.ReqValid     = 1'b1;
    bus.ReqOp        = SW;
    bus.ReqAddr      = 32'h10;
    bus.ReqWriteData = 32'h1;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.ReqReady, bus.RespValid, bus.Misaligned, bus.OutOfRange,
         bus.MemoryRead, bus.MemoryWrite} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b required 000000", {bus.ReqReady, bus.RespValid,
               bus.Misaligned, bus.OutOfRange, bus.MemoryRead, bus.MemoryWrite});
    end
    tests++;
    if ({bus.MemAddress, bus.MemWriteData, bus.RespData} !== '0) begin
      fails++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h required 0", bus.MemAddress,
               bus.MemWriteData, bus.RespData);
    end
    bus.ReqValid = 1'b0;
    rst          = 1'b0;
    mem_clear    = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.ReqReady !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b required 1", bus.ReqReady);
    end
  endtask

  task automatic test_store_load();
    obs_t o, e;
    issue(SW, 32'h10, 32'hDEAD_BEEF, o);
    model(SW, 32'h10, 32'hDEAD_BEEF, e);
    tests++;
    if ({o.lat, o.nwr, o.wr_cyc, o.nrd, o.addr, o.data} !== {4'd1, 4'd1, 4'd1, 4'd0, 6'd4, 32'd0}) begin
      fails++;
      $display("FAIL sw_word4: lat=%0d nwr=%0d wcyc=%0d nrd=%0d addr=%0d data=%h required 1 1 1 0 4 0",
               o.lat, o.nwr, o.wr_cyc, o.nrd, o.addr, o.data);
    end
    issue(LW, 32'h10, 32'h0, o);
    model(LW, 32'h10, 32'h0, e);
    tests++;
    if ({o.lat, o.nrd, o.rd_cyc, o.nwr, o.data} !== {4'd2, 4'd1, 4'd1, 4'd0, 32'hDEAD_BEEF}) begin
      fails++;
      $display("FAIL lw_word4: lat=%0d nrd=%0d rcyc=%0d nwr=%0d data=%h required 2 1 1 0 deadbeef",
               o.lat, o.nrd, o.rd_cyc, o.nwr, o.data);
    end
  endtask

  task automatic test_subword_loads();
    lsu_op_t     ops [4] = '{LB, LBU, LH, LHU};
    logic [31:0] adr [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] want[4] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF};
    obs_t o, e;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], adr[i], 32'h0, o);
      model(ops[i], adr[i], 32'h0, e);
      tests++;
      if (o.data !== want[i] || o.lat !== 4'd2) begin
        fails++;
        $display("FAIL subword_load_%0d: data=%h lat=%0d required %h 2", i, o.data, o.lat, want[i]);
      end
    end
  endtask

  task automatic test_rmw();
    obs_t o, e;
    issue(SB, 32'h11, 32'h1234_5677, o);
    model(SB, 32'h11, 32'h1234_5677, e);
    tests++;
    if ({o.rd_cyc, o.wr_cyc, o.nrd, o.nwr, o.both, o.lat} !== {4'd1, 4'd2, 4'd1, 4'd1, 1'b0, 4'd2}) begin
      fails++;
      $display("FAIL sb_strobes: rcyc=%0d wcyc=%0d nrd=%0d nwr=%0d both=%b lat=%0d required 1 2 1 1 0 2",
               o.rd_cyc, o.wr_cyc, o.nrd, o.nwr, o.both, o.lat);
    end
    issue(LW, 32'h10, 32'h0, o);
    model(LW, 32'h10, 32'h0, e);
    tests++;
    if (o.data !== 32'hDEAD_77EF) begin
      fails++;
      $display("FAIL sb_merge: got %h required dead77ef", o.data);
    end
    issue(SH, 32'h12, 32'hAAAA_5555, o);
    model(SH, 32'h12, 32'hAAAA_5555, e);
    issue(LW, 32'h10, 32'h0, o);
    model(LW, 32'h10, 32'h0, e);
    tests++;
    if (o.data !== 32'h5555_77EF) begin
      fails++;
      $display("FAIL sh_merge: got %h required 555577ef", o.data);
    end
  endtask

  task automatic test_faults();
    lsu_op_t     ops [5] = '{LW, LW, LH, SW, SB};
    logic [31:0] adr [5] = '{32'h12, 32'h100, 32'h101, 32'hFC, 32'hFF};
    logic [1:0]  flag[5] = '{2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
    obs_t o, e;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], adr[i], 32'hCAFE_0000 | i, o);
      model(ops[i], adr[i], 32'hCAFE_0000 | i, e);
      tests++;
      if ({o.mis, o.oor} !== flag[i] || o !== e) begin
        fails++;
        $display("FAIL fault_%0d: got %h required %h flags %b", i, o, e, flag[i]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    obs_t o, e;
    logic seen;
    start_req(SB, 32'h10, 32'h0000_00FF);
    tests++;
    if (bus.MemoryRead !== 1'b1) begin
      fails++;
      $display("FAIL rmw_rd_strobe: got %b required 1", bus.MemoryRead);
    end
    rst  = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | bus.MemoryWrite | bus.RespValid;
    end
    rst = 1'b0;
    @(negedge clk);
    seen = seen | bus.MemoryWrite | bus.RespValid;
    tests++;
    if (seen !== 1'b0 || bus.ReqReady !== 1'b1) begin
      fails++;
      $display("FAIL rmw_reset_abort: write_or_resp=%b ready=%b required 0 1", seen, bus.ReqReady);
    end
    issue(LW, 32'h10, 32'h0, o);
    model(LW, 32'h10, 32'h0, e);
    tests++;
    if (o.data !== e.data) begin
      fails++;
      $display("FAIL rmw_reset_mem: got %h required %h", o.data, e.data);
    end
    start_req(LW, 32'h10, 32'h0);
    rst  = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | bus.RespValid;
    end
    rst = 1'b0;
    @(negedge clk);
    seen = seen | bus.RespValid;
    tests++;
    if (seen !== 1'b0 || bus.ReqReady !== 1'b1) begin
      fails++;
      $display("FAIL ld_reset_abort: resp=%b ready=%b required 0 1", seen, bus.ReqReady);
    end
  endtask

  task automatic test_back_to_back();
    lsu_op_t     ops [3] = '{SW, LW, SB};
    logic [31:0] adr [3] = '{32'h20, 32'h20, 32'h21};
    int          want_acc[3] = '{0, 2, 5};
    int          want_rsp[3] = '{1, 4, 7};
    logic [31:0] dat [3];
    logic [31:0] rsp_d[3];
    int          acc_t[3] = '{-1, -1, -1};
    int          rsp_t[3] = '{-1, -1, -1};
    obs_t        e[3];
    obs_t        o, ef;
    int          k = 0;
    int          np = 0;
    int          busy_low = 0;
    logic        rdy;
    for (int i = 0; i < 3; i++) begin
      dat[i]   = $urandom;
      rsp_d[i] = 32'hX;
      model(ops[i], adr[i], dat[i], e[i]);
    end
    @(negedge clk);
    bus.ReqValid     = 1'b1;
    bus.ReqOp        = ops[0];
    bus.ReqAddr      = adr[0];
    bus.ReqWriteData = dat[0];
    for (int t = 0; t < 10; t++) begin
      rdy = bus.ReqReady;
      if (!rdy) busy_low++;
      if (bus.RespValid && np < 3) begin
        rsp_t[np] = t;
        rsp_d[np] = bus.RespData;
        np++;
      end
      @(posedge clk);
      if (rdy && bus.ReqValid && k < 3) begin
        acc_t[k] = t;
        k++;
        #1;
        if (k < 3) begin
          bus.ReqOp        = ops[k];
          bus.ReqAddr      = adr[k];
          bus.ReqWriteData = dat[k];
        end else begin
          bus.ReqValid = 1'b0;
        end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (acc_t[i] !== want_acc[i] || rsp_t[i] !== want_rsp[i] || rsp_d[i] !== e[i].data) begin
        fails++;
        $display("FAIL b2b_req%0d: accept=%0d resp=%0d data=%h required %0d %0d %h", i,
                 acc_t[i], rsp_t[i], rsp_d[i], want_acc[i], want_rsp[i], e[i].data);
      end
    end
    tests++;
    if (busy_low !== 5 || np !== 3) begin
      fails++;
      $display("FAIL b2b_ready: busy_low=%0d pulses=%0d required 5 3", busy_low, np);
    end
    issue(LW, 32'h20, 32'h0, o);
    model(LW, 32'h20, 32'h0, ef);
    tests++;
    if (o.data !== ef.data) begin
      fails++;
      $display("FAIL b2b_final_word: got %h required %h", o.data, ef.data);
    end
  endtask

  task automatic test_random();
    obs_t        o, e;
    lsu_op_t     op;
    logic [31:0] addr;
    logic [31:0] data;
    for (int i = 0; i < 60; i++) begin
      op   = lsu_op_t'($urandom_range(0, 7));
      addr = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h100) : 32'($urandom_range(0, 255));
      data = $urandom;
      issue(op, addr, data, o);
      model(op, addr, data, e);
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL random_%0d op=%0d addr=%h: got %h required %h", i, op, addr, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_subword_loads();
    test_rmw();
    test_faults();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
